periph_slot_demux: RTL and testbench

Routes the single data port of a cluster core (core_data_req_t / core_data_rsp_t) to the cluster peripheral slave slots. The target slot comes from address bits [13:10], in 1 KiB slots; the event unit occupies two slots. The block sits directly downstream of the core data interface and upstream of the per-slot cluster peripherals (EOC, timer, event unit, HWPE, I$ ctrl, DMA, HMR, scrubber, ext). It tracks outstanding transactions so responses return to the core in order. Unmapped or out-of-range slots are answered by an internal error responder.

---
 rtl/periph_slot_demux.sv | 143 ++++++++++++++
 tb/tb_periph_slot_demux.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_slot_demux.sv
// rtl/periph_slot_demux.sv - core data port demux onto cluster peripheral slots with in-order response return
package periph_slot_demux_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;

endpackage

module periph_slot_demux
  import periph_slot_demux_pkg::*;
#(
  parameter int unsigned NumSlaves      = 11,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [31:0] ErrorData      = 32'hBADACCE5,
  localparam int unsigned CntW          = $clog2(MaxOutstanding) + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  core_data_req_t mst_req_i,
  output core_data_rsp_t mst_rsp_o,
  output core_data_req_t slv_req_o [NumSlaves],
  input  core_data_rsp_t slv_rsp_i [NumSlaves],
  output logic           err_o,
  output logic [CntW-1:0] outstanding_o
);

  localparam int unsigned IdW  = $clog2(NumSlaves + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [IdW-1:0] ErrId = IdW'(NumSlaves);

  logic [3:0]      slot;
  logic [IdW-1:0]  dec_id;
  logic            dec_err;
  logic            slv_gnt;
  logic            mst_gnt;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [IdW-1:0]  id_mem [MaxOutstanding];
  logic [IdW-1:0]  head_id;
  logic            rsp_valid;
  logic [31:0]     rsp_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // The event unit spans two 1 KiB slots, so slot 3 folds onto slave 2.
  assign slot = mst_req_i.add[13:10];

  always_comb begin
    dec_id = IdW'(slot);
    if (slot == 4'd3 && NumSlaves > 3) begin
      dec_id = IdW'(2);
    end else if (32'(slot) >= NumSlaves) begin
      dec_id = ErrId;
    end
  end

  assign dec_err = (dec_id == ErrId);
  assign full    = (count == CntW'(MaxOutstanding));
  assign empty   = (count == '0);

  always_comb begin
    slv_gnt = 1'b0;
    for (int unsigned s = 0; s < NumSlaves; s++) begin
      slv_req_o[s]     = mst_req_i;
      slv_req_o[s].req = mst_req_i.req && !full && (dec_id == IdW'(s));
      if (dec_id == IdW'(s)) begin
        slv_gnt = slv_rsp_i[s].gnt;
      end
    end
  end

  assign mst_gnt = !full && (dec_err || slv_gnt);
  assign push    = mst_req_i.req && mst_gnt;
  assign err_o   = push && dec_err;

  assign head_id = id_mem[rd_ptr];

  // Only the slave at the FIFO head may answer; the error target answers as soon as it is head.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (!empty) begin
      if (head_id == ErrId) begin
        rsp_valid = 1'b1;
        rsp_data  = ErrorData;
      end else begin
        for (int unsigned s = 0; s < NumSlaves; s++) begin
          if (head_id == IdW'(s)) begin
            rsp_valid = slv_rsp_i[s].r_valid;
            rsp_data  = slv_rsp_i[s].r_data;
          end
        end
      end
    end
  end

  assign pop           = rsp_valid;
  assign mst_rsp_o     = {mst_gnt, rsp_data, rsp_valid};
  assign outstanding_o = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        id_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= dec_id;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CntW'(1);
      end else if (pop && !push) begin
        count <= count - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_periph_slot_demux.sv
// tb/tb_periph_slot_demux.sv - table and scoreboard driven bench for periph_slot_demux
module tb_periph_slot_demux;
  import periph_slot_demux_pkg::*;

  localparam int NS = 11;
  localparam int MO = 4;
  localparam logic [31:0] ERR_DATA = 32'hBADACCE5;

  logic           clk = 1'b0;
  logic           rst_n;
  core_data_req_t mst_req;
  core_data_rsp_t mst_rsp;
  core_data_req_t slv_req [NS];
  core_data_rsp_t slv_rsp [NS];
  logic           err;
  logic [2:0]     outstanding;

  periph_slot_demux #(
    .NumSlaves     (NS),
    .MaxOutstanding(MO),
    .ErrorData     (ERR_DATA)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mst_req_i    (mst_req),
    .mst_rsp_o    (mst_rsp),
    .slv_req_o    (slv_req),
    .slv_rsp_i    (slv_rsp),
    .err_o        (err),
    .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
    int          exp_slave;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [16];
  int   exp_map [16] = '{0, 1, 2, 2, 4, 5, 6, 7, 8, 9, 10, -1, -1, -1, -1, -1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NS-1:0] req_bits();
    logic [NS-1:0] b;
    for (int s = 0; s < NS; s++) b[s] = slv_req[s].req;
    return b;
  endfunction

  task automatic set_slaves(input logic g);
    for (int s = 0; s < NS; s++) begin
      slv_rsp[s].gnt     = g;
      slv_rsp[s].r_valid = 1'b0;
      slv_rsp[s].r_data  = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response the core sees must match the oldest expected entry.
  always @(negedge clk) begin
    if (mst_rsp.r_valid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_r_valid", 32'(mst_rsp.r_valid), 32'd0);
      else check("sb_r_data", mst_rsp.r_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NS-1:0] exp_bits;
    logic [31:0]   d [5];
    int            es;
    int            k;

    for (int i = 0; i < 16; i++) begin
      vecs[i].add       = {18'($urandom), 4'(i), 10'($urandom)};
      vecs[i].we        = 1'(i);
      vecs[i].data      = $urandom;
      vecs[i].be        = 4'($urandom);
      vecs[i].exp_slave = exp_map[i];
      vecs[i].rdata     = $urandom;
    end

    rst_n = 1'b0;
    mst_req = '0;
    mst_req.add = 32'h0000_0400;
    set_slaves(1'b1);
    repeat (2) @(posedge clk);
    #2;
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_r_valid", 32'(mst_rsp.r_valid), 32'd0);
    check("rst_r_data", mst_rsp.r_data, 32'd0);
    check("rst_err_o", 32'(err), 32'd0);
    check("rst_slv_req", 32'(req_bits()), 32'd0);
    check("rst_gnt_comb", 32'(mst_rsp.gnt), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table: one transaction per slot 0..15
    for (int i = 0; i < 16; i++) begin
      es = vecs[i].exp_slave;
      exp_bits = (es >= 0) ? (NS'(1) << es) : '0;
      mst_req.req  = 1'b1;
      mst_req.add  = vecs[i].add;
      mst_req.we   = vecs[i].we;
      mst_req.data = vecs[i].data;
      mst_req.be   = vecs[i].be;
      #1;
      check("vec_slv_req", 32'(req_bits()), 32'(exp_bits));
      check("vec_gnt", 32'(mst_rsp.gnt), 32'd1);
      check("vec_err_o", 32'(err), 32'(es < 0));
      k = i % NS;
      check("vec_fanout_add", slv_req[k].add, vecs[i].add);
      check("vec_fanout_data", slv_req[k].data, vecs[i].data);
      check("vec_fanout_we_be", 32'({slv_req[k].be, slv_req[k].we}), 32'({vecs[i].be, vecs[i].we}));
      exp_q.push_back((es < 0) ? ERR_DATA : vecs[i].rdata);
      tick();
      mst_req.req = 1'b0;
      if (es >= 0) begin
        slv_rsp[es].r_valid = 1'b1;
        slv_rsp[es].r_data  = vecs[i].rdata;
      end
      #1;
      check("vec_outstanding_1", 32'(outstanding), 32'd1);
      check("vec_resp_valid", 32'(mst_rsp.r_valid), 32'd1);
      check("vec_err_o_low", 32'(err), 32'd0);
      tick();
      set_slaves(1'b1);
      #1;
      check("vec_outstanding_0", 32'(outstanding), 32'd0);
      check("vec_idle_r_valid", 32'(mst_rsp.r_valid), 32'd0);
      check("vec_idle_r_data", mst_rsp.r_data, 32'd0);
    end

    // Ordering: slot 5, ERR, slot 0; slave 0 answers early and must wait
    mst_req.req = 1'b1;
    mst_req.add = 32'h0000_1400;
    #1;
    check("ord_gnt_s5", 32'(mst_rsp.gnt), 32'd1);
    exp_q.push_back(32'h5555_0005);
    tick();
    mst_req.add = 32'h0000_2C00;
    #1;
    check("ord_gnt_err", 32'(mst_rsp.gnt), 32'd1);
    check("ord_err_o", 32'(err), 32'd1);
    check("ord_err_no_slv_req", 32'(req_bits()), 32'd0);
    exp_q.push_back(ERR_DATA);
    tick();
    mst_req.add = 32'h0000_0000;
    #1;
    check("ord_slv_req_s0", 32'(req_bits()), 32'd1);
    exp_q.push_back(32'h0A0A_0000);
    tick();
    mst_req.req = 1'b0;
    slv_rsp[5].r_valid = 1'b1;
    slv_rsp[5].r_data  = 32'h5555_0005;
    slv_rsp[0].r_valid = 1'b1;
    slv_rsp[0].r_data  = 32'h0A0A_0000;
    #1;
    check("ord_outstanding_3", 32'(outstanding), 32'd3);
    check("ord_first_s5", mst_rsp.r_data, 32'h5555_0005);
    tick();
    slv_rsp[5].r_valid = 1'b0;
    #1;
    check("ord_second_err", mst_rsp.r_data, ERR_DATA);
    tick();
    #1;
    check("ord_third_s0", mst_rsp.r_data, 32'h0A0A_0000);
    check("ord_outstanding_1", 32'(outstanding), 32'd1);
    tick();
    slv_rsp[0].r_valid = 1'b0;
    #1;
    check("ord_drained", 32'(outstanding), 32'd0);

    // Full: four in flight block the fifth until a pop
    for (int j = 0; j < 5; j++) d[j] = 32'hF000_0000 + 32'(j);
    mst_req.req = 1'b1;
    mst_req.add = 32'h0000_0400;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("full_gnt_pre", 32'(mst_rsp.gnt), 32'd1);
      exp_q.push_back(d[j]);
      tick();
    end
    #1;
    check("full_gnt_blocked", 32'(mst_rsp.gnt), 32'd0);
    check("full_slv_req_blocked", 32'(req_bits()), 32'd0);
    check("full_outstanding_4", 32'(outstanding), 32'd4);
    slv_rsp[1].r_valid = 1'b1;
    slv_rsp[1].r_data  = d[0];
    #1;
    check("full_gnt_during_pop", 32'(mst_rsp.gnt), 32'd0);
    tick();
    slv_rsp[1].r_valid = 1'b0;
    #1;
    check("full_gnt_after_pop", 32'(mst_rsp.gnt), 32'd1);
    check("full_slv_req_after_pop", 32'(req_bits()), 32'd2);
    check("full_outstanding_3", 32'(outstanding), 32'd3);
    exp_q.push_back(d[4]);
    tick();
    mst_req.req = 1'b0;
    for (int j = 1; j < 5; j++) begin
      slv_rsp[1].r_valid = 1'b1;
      slv_rsp[1].r_data  = d[j];
      tick();
    end
    slv_rsp[1].r_valid = 1'b0;
    #1;
    check("full_drained", 32'(outstanding), 32'd0);

    // Reset with two in flight; the late slave response must be dropped
    mst_req.req = 1'b1;
    mst_req.add = 32'h0000_1800;
    tick();
    tick();
    mst_req.req = 1'b0;
    #1;
    check("rmf_outstanding_2", 32'(outstanding), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rmf_async_clear", 32'(outstanding), 32'd0);
    tick();
    rst_n = 1'b1;
    slv_rsp[6].r_valid = 1'b1;
    slv_rsp[6].r_data  = 32'hDEAD_BEEF;
    #1;
    check("rmf_r_valid", 32'(mst_rsp.r_valid), 32'd0);
    check("rmf_r_data", mst_rsp.r_data, 32'd0);
    check("rmf_outstanding", 32'(outstanding), 32'd0);
    check("rmf_err_o", 32'(err), 32'd0);
    tick();
    set_slaves(1'b1);
    tick();

    check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
